// File: rtl/poly_compress_collect.sv
// poly_compress_collect: streams 12-bit coefficients through Compress_D and
// collects 256 results into a polynomial buffer presented on f_o.
// Optional build macro: POLY_COMPRESS_REDUCE_EN (one conditional subtraction
// of Q on the input before compression).
module poly_compress_collect #(
  parameter int unsigned D        = 10,
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned Q        = 3329
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          coef_valid_i,
  output logic                          coef_ready_o,
  input  logic [11:0]                   coef_i,
  output logic                          poly_valid_o,
  input  logic                          poly_ready_i,
  output logic [255:0][IN_WIDTH-1:0]    f_o,
  output logic [8:0]                    count_o
);

  localparam int unsigned CW     = 12;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned N_COEF = 256;
  localparam int unsigned ROUND  = Q / 2;
  // Reciprocal shift: with K=36 the magic-multiply error term (<Q) stays below
  // 2^(K-24), so floor(n/Q) is exact for every n < 2^24.
  localparam int unsigned K      = 36;
  localparam int unsigned PROD_W = 50;
  localparam logic [PROD_W-1:0] MAGIC =
    PROD_W'(((64'd1 << K) + 64'(Q) - 64'd1) / 64'(Q));

  typedef enum logic [0:0] {ST_FILL, ST_FULL} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             acc_q, acc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         ready_q, ready_d;
  logic                         s1_vld_q, s2_vld_q;
  logic [PROD_W-1:0]            s1_q, s1_d;
  logic [CW-1:0]                s2_q, s2_d;
  logic [255:0][IN_WIDTH-1:0]   buf_q;
  logic [CW-1:0]                x_red;
  logic                         fire;
  logic                         unused_s1;

  assign fire         = coef_valid_i && ready_q;
  assign coef_ready_o = ready_q;
  assign poly_valid_o = (state_q == ST_FULL);
  assign f_o          = buf_q;
  assign count_o      = cnt_q;
  assign unused_s1    = ^s1_q;

  // Optional input reduction into 0..Q-1
  always_comb begin
    x_red = coef_i;
`ifdef POLY_COMPRESS_REDUCE_EN
    if (coef_i >= CW'(Q)) begin
      x_red = coef_i - CW'(Q);
    end
`endif
  end

  // Stage-1 datapath: scale, round and multiply by the reciprocal of Q
  always_comb begin
    if (D == 12) begin
      s1_d = PROD_W'(x_red);
    end else begin
      s1_d = ((PROD_W'(x_red) << D) + PROD_W'(ROUND)) * MAGIC;
    end
  end

  // Stage-2 datapath: quotient bits taken modulo 2^D
  always_comb begin
    if (D == 12) begin
      s2_d = s1_q[CW-1:0];
    end else begin
      s2_d = CW'(s1_q[K +: D]);
    end
  end

  // Pipeline registers with per-stage valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      s1_vld_q <= fire;
      s2_vld_q <= s1_vld_q;
      if (fire) begin
        s1_q <= s1_d;
      end
      if (s1_vld_q) begin
        s2_q <= s2_d;
      end
    end
  end

  // Polynomial buffer, written at the current fill index
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q <= '0;
    end else if (s2_vld_q) begin
      buf_q[cnt_q[7:0]] <= IN_WIDTH'(s2_q);
    end
  end

  // Control state, counters and registered ready
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FILL;
      acc_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: fill until 256 writes land, then hold until consumed
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (fire) begin
          acc_d = acc_q + CNT_W'(1);
        end
        if (s2_vld_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_COEF - 1)) begin
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (poly_ready_i) begin
          state_d = ST_FILL;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
    ready_d = (state_d == ST_FILL) && (acc_d < CNT_W'(N_COEF));
  end

endmodule

// File: tb/tb_poly_compress_collect.sv
// Directed bench for poly_compress_collect: four instances (D=10,4,1,12)
// share one input stream and are checked against a division-based model.
module tb_poly_compress_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        cv;
  logic        pr;
  logic [11:0] ci;

  logic                  rdy10, rdy4, rdy1, rdy12;
  logic                  pv10, pv4, pv1, pv12;
  logic [255:0][15:0]    f10, f4, f1, f12, snap;
  logic [8:0]            cnt10, cnt4, cnt1, cnt12;

  int unsigned stim [256];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;

  always #5 clk = ~clk;

  poly_compress_collect #(.D(10), .IN_WIDTH(16), .Q(3329)) u10 (
    .clk_i(clk), .rst_i(rst), .coef_valid_i(cv), .coef_ready_o(rdy10),
    .coef_i(ci), .poly_valid_o(pv10), .poly_ready_i(pr), .f_o(f10), .count_o(cnt10));
  poly_compress_collect #(.D(4), .IN_WIDTH(16), .Q(3329)) u4 (
    .clk_i(clk), .rst_i(rst), .coef_valid_i(cv), .coef_ready_o(rdy4),
    .coef_i(ci), .poly_valid_o(pv4), .poly_ready_i(pr), .f_o(f4), .count_o(cnt4));
  poly_compress_collect #(.D(1), .IN_WIDTH(16), .Q(3329)) u1 (
    .clk_i(clk), .rst_i(rst), .coef_valid_i(cv), .coef_ready_o(rdy1),
    .coef_i(ci), .poly_valid_o(pv1), .poly_ready_i(pr), .f_o(f1), .count_o(cnt1));
  poly_compress_collect #(.D(12), .IN_WIDTH(16), .Q(3329)) u12 (
    .clk_i(clk), .rst_i(rst), .coef_valid_i(cv), .coef_ready_o(rdy12),
    .coef_i(ci), .poly_valid_o(pv12), .poly_ready_i(pr), .f_o(f12), .count_o(cnt12));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model(input int unsigned d, input int unsigned x);
    int unsigned xr;
    xr = x;
`ifdef POLY_COMPRESS_REDUCE_EN
    if (xr >= 3329) xr = xr - 3329;
`endif
    if (d == 12) return xr;
    return (((xr << d) + 1664) / 3329) % (32'd1 << d);
  endfunction

  // Drive n coefficients from stim, honouring ready; returns one negedge
  // after the last accepting edge with valid set to keep_valid.
  task automatic send(input int n, input bit gaps, input bit keep_valid, output int cycles);
    int i;
    i = 0;
    cycles = 0;
    while (i < n && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        cv = 1'b0;
        ci = 12'hABC;
      end else begin
        cv = 1'b1;
        ci = 12'(stim[i]);
      end
      if (cv && rdy10) i++;
    end
    check("send_count", i, n);
    @(negedge clk);
    cv = keep_valid;
    ci = 12'hFFF;
  endtask

  task automatic wait_full();
    int k;
    k = 0;
    while (!pv10 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("wait_full", 32'(pv10), 1);
  endtask

  task automatic check_poly(input string tag);
    check($sformatf("%s_cnt10", tag), cnt10, 256);
    check($sformatf("%s_cnt4", tag), cnt4, 256);
    check($sformatf("%s_cnt1", tag), cnt1, 256);
    check($sformatf("%s_cnt12", tag), cnt12, 256);
    check($sformatf("%s_pv", tag), {pv10, pv4, pv1, pv12}, 4'hF);
    check($sformatf("%s_rdy", tag), {rdy10, rdy4, rdy1, rdy12}, 4'h0);
    for (int i = 0; i < 256; i++) begin
      check($sformatf("%s_d10[%0d]", tag, i), f10[i], model(10, stim[i]));
      check($sformatf("%s_d4[%0d]", tag, i), f4[i], model(4, stim[i]));
      check($sformatf("%s_d1[%0d]", tag, i), f1[i], model(1, stim[i]));
      check($sformatf("%s_d12[%0d]", tag, i), f12[i], model(12, stim[i]));
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    cv = 1'b0;
    pr = 1'b1;
    @(negedge clk);
    pr = 1'b0;
    check($sformatf("%s_hs_cnt", tag), cnt10, 0);
    check($sformatf("%s_hs_rdy", tag), 32'(rdy10), 1);
    check($sformatf("%s_hs_pv", tag), 32'(pv10), 0);
  endtask

  task automatic run_const(input int unsigned v, input string tag);
    for (int i = 0; i < 256; i++) stim[i] = v;
    send(256, 1'b1, 1'b0, cyc);
    wait_full();
    check_poly(tag);
  endtask

  initial begin
    rst = 1'b1;
    cv  = 1'b0;
    pr  = 1'b0;
    ci  = '0;
    repeat (3) @(negedge clk);
    check("rst_rdy_low", 32'(rdy10), 0);
    check("rst_pv_low", 32'(pv10), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", {rdy10, rdy4, rdy1, rdy12}, 4'hF);
    check("post_rst_cnt", cnt10, 0);
    check("post_rst_f", 32'((f10 != '0) || (f12 != '0)), 0);

    // Ramp 0..255 at full rate, valid held high through FULL
    for (int i = 0; i < 256; i++) stim[i] = i;
    send(256, 1'b0, 1'b1, cyc);
    check("tp_cycles", cyc, 256);
    check("tp_rdy_drop", 32'(rdy10), 0);
    check("tp_pv_e0", 32'(pv10), 0);
    check("tp_cnt_e0", cnt10, 254);
    @(negedge clk);
    check("tp_pv_e1", 32'(pv10), 0);
    @(negedge clk);
    check("tp_pv_e2", 32'(pv10), 1);
    check_poly("ramp");
    check("hand_ramp_f3", f10[3], 1);
    snap = f10;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ci = 12'($urandom_range(0, 4095));
    end
    check("hold_f_stable", 32'(f10 == snap), 1);
    check("hold_pv", 32'(pv10), 1);
    check("hold_cnt", cnt10, 256);
    handshake("ramp");

    // Constant streams with random valid gaps; poly_ready held high in FILL
    pr = 1'b1;
    for (int i = 0; i < 256; i++) stim[i] = 1000;
    send(256, 1'b1, 1'b0, cyc);
    pr = 1'b0;
    wait_full();
    check_poly("x1000");
    check("hand_d10_x1000", f10[200], 308);
    handshake("x1000");

    run_const(3328, "x3328");
    check("hand_d4_x3328", f4[17], 0);
    check("hand_d12_x3328", f12[17], 3328);
    handshake("x3328");

    run_const(832, "x832");
    check("hand_d1_x832", f1[50], 0);
    handshake("x832");

    run_const(833, "x833");
    check("hand_d1_x833", f1[50], 1);
    handshake("x833");

    run_const(3329, "x3329");
`ifdef POLY_COMPRESS_REDUCE_EN
    check("hand_d12_x3329", f12[99], 0);
`else
    check("hand_d12_x3329", f12[99], 3329);
`endif
    handshake("x3329");

    // Reset with two coefficients still in the pipeline
    for (int i = 0; i < 256; i++) stim[i] = (i * 13 + 7) % 4096;
    send(100, 1'b0, 1'b0, cyc);
    check("mid_cnt_pre", cnt10, 98);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cnt", cnt10, 0);
    check("mid_rst_pv", 32'(pv10), 0);
    check("mid_rst_f", 32'((f10 != '0) || (f4 != '0) || (f1 != '0) || (f12 != '0)), 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_post_rdy", 32'(rdy10), 1);

    // Fresh full-range stream after the mid-fill reset
    for (int i = 0; i < 256; i++) stim[i] = $urandom_range(0, 4095);
    stim[0] = 4095;
    stim[1] = 3329;
    stim[2] = 3328;
    stim[3] = 0;
    send(256, 1'b1, 1'b0, cyc);
    wait_full();
    check_poly("fresh");
    check("hand_fresh_d10_0", f10[3], 0);
    handshake("fresh");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
